split_reg: RTL

SPLIT_REG -- requirements
Module: split_reg

---
 rtl/split_reg_if.sv | 51 +++++
 rtl/split_reg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/split_reg_if.sv
// split_reg_if -- bus bundle between one master and N_SLAVES slaves of the
// address-split register router.
//   master side : m_valid/m_addr/m_wdata/m_wstrb in, m_rdata/m_ready back
//   slave side  : one-hot s_valid, shared s_addr/s_wdata/s_wstrb,
//                 packed s_rdata (slave i at [i*DATA_W +: DATA_W]), s_ready
//   status      : err_clr in, sticky err_cause out
// Modport "slave" is the router's view; "master" is the view of whoever
// drives requests and models the slaves.
interface split_reg_if #(
    parameter int N_SLAVES = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    localparam int SEL_W   = (N_SLAVES > 2) ? $clog2(N_SLAVES) : 1;
    localparam int SADDR_W = ADDR_W - SEL_W;

    logic                       m_valid;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic [DATA_W/8-1:0]        m_wstrb;
    logic [DATA_W-1:0]          m_rdata;
    logic                       m_ready;

    logic [N_SLAVES-1:0]        s_valid;
    logic [SADDR_W-1:0]         s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic [DATA_W/8-1:0]        s_wstrb;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;
    logic [N_SLAVES-1:0]        s_ready;

    logic                       err_clr;
    logic [1:0]                 err_cause;

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ready,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_rdata, s_ready,
        input  err_clr,
        output err_cause
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ready,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_rdata, s_ready,
        output err_clr,
        input  err_cause
    );
endinterface

// File: rtl/split_reg.sv
// split_reg -- routes one master register transaction at a time to one of
// N_SLAVES slaves, selected by the top SEL_W address bits.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : split_reg_if.slave (master request/response, slave fan-out,
//             err_clr / err_cause status)
// Unmapped selects and slaves that do not answer within TIMEOUT cycles
// complete with ERR_DATA and set a sticky bit in err_cause. All outputs are
// registered; their next values are derived from the next FSM state.
module split_reg #(
    parameter int                N_SLAVES = 3,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic        clk,
    input  logic        rst_n,
    split_reg_if.slave  bus
);
    localparam int SEL_W   = (N_SLAVES > 2) ? $clog2(N_SLAVES) : 1;
    localparam int SADDR_W = ADDR_W - SEL_W;
    localparam int STRB_W  = DATA_W / 8;
    localparam int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    // Select values at or above this are unmapped; one extra bit so that
    // N_SLAVES == 2**SEL_W is representable.
    localparam logic [SEL_W:0]   N_SEL = (SEL_W + 1)'(N_SLAVES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t              state, state_n;
    logic [SEL_W-1:0]    sel, sel_n;
    logic [CNT_W-1:0]    cnt, cnt_n;

    logic [N_SLAVES-1:0] s_valid_q, s_valid_n;
    logic [SADDR_W-1:0]  s_addr_q, s_addr_n;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_n;
    logic [STRB_W-1:0]   s_wstrb_q, s_wstrb_n;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_n;
    logic                m_ready_q, m_ready_n;
    logic [1:0]          err_q, err_n;

    logic [SEL_W-1:0]    req_sel;
    logic                sel_rdy;
    logic [DATA_W-1:0]   sel_rdata;
    logic                set_unmap, set_tmo;

    assign req_sel = bus.m_addr[ADDR_W-1 -: SEL_W];

    // Only the latched slave's ready/rdata are ever looked at.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == i[SEL_W-1:0]) begin
                sel_rdy   = bus.s_ready[i];
                sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        cnt_n     = cnt;
        s_addr_n  = s_addr_q;
        s_wdata_n = s_wdata_q;
        s_wstrb_n = s_wstrb_q;
        m_rdata_n = m_rdata_q;
        set_unmap = 1'b0;
        set_tmo   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.m_valid) begin
                    sel_n     = req_sel;
                    cnt_n     = '0;
                    s_addr_n  = bus.m_addr[SADDR_W-1:0];
                    s_wdata_n = bus.m_wdata;
                    s_wstrb_n = bus.m_wstrb;
                    if ({1'b0, req_sel} < N_SEL) begin
                        state_n = REQ;
                    end else begin
                        state_n   = ERR;
                        set_unmap = 1'b1;
                    end
                end
            end
            REQ: begin
                // A ready arriving on the limit cycle still completes normally.
                if (sel_rdy) begin
                    m_rdata_n = sel_rdata;
                    state_n   = RESP;
                end else if (TIMEOUT != 0 && cnt == LIMIT) begin
                    state_n = ERR;
                    set_tmo = 1'b1;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        m_ready_n = (state_n == RESP) || (state_n == ERR);
        if (state_n == ERR) m_rdata_n = ERR_DATA;

        s_valid_n = '0;
        if (state_n == REQ) begin
            for (int i = 0; i < N_SLAVES; i++)
                s_valid_n[i] = (sel_n == i[SEL_W-1:0]);
        end

        // A set event on the clearing cycle survives the clear.
        err_n = (bus.err_clr ? 2'b00 : err_q) | {set_tmo, set_unmap};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            cnt       <= '0;
            s_valid_q <= '0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
            m_rdata_q <= '0;
            m_ready_q <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            cnt       <= cnt_n;
            s_valid_q <= s_valid_n;
            s_addr_q  <= s_addr_n;
            s_wdata_q <= s_wdata_n;
            s_wstrb_q <= s_wstrb_n;
            m_rdata_q <= m_rdata_n;
            m_ready_q <= m_ready_n;
            err_q     <= err_n;
        end
    end

    assign bus.s_valid   = s_valid_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.s_wstrb   = s_wstrb_q;
    assign bus.m_rdata   = m_rdata_q;
    assign bus.m_ready   = m_ready_q;
    assign bus.err_cause = err_q;
endmodule
